// File: rtl/pipe_ctrl_gen.sv
// rtl/pipe_ctrl_gen.sv - pipeline hazard controller: stall/bubble merge, flush vs redirect arbitration, stall watchdog
module pipe_ctrl_gen #(
    parameter int STAGES   = 6,
    parameter int BR_STAGE = 2,
    parameter int PC_W     = 32,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              ex_req,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              br_req,
    input  logic [PC_W-1:0]   br_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              redirect,
    output logic [PC_W-1:0]   redir_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              timeout
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    if (BR_STAGE < 1 || BR_STAGE >= STAGES || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_param
        $error("pipe_ctrl_gen: illegal parameter combination");
    end

    logic [STAGES-1:0] merged;
    logic [STAGES-1:0] bub_raw;
    logic              req_any;
    logic              active;
    logic              freeze;

    logic              pend_valid_q, pend_valid_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    // A hold request from stage j freezes every older slot 0..j.
    always_comb begin
        req_any = 1'b0;
        merged  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            req_any   = req_any | stall_req[i];
            merged[i] = req_any;
        end
        bub_raw = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            bub_raw[i] = merged[i] & ~merged[i+1];
        end
    end

    assign active = rst & ~ex_req;
    assign freeze = merged[0];

    always_comb begin
        stall    = active ? merged  : '0;
        bubble   = active ? bub_raw : '0;
        flush    = rst & ex_req;
        new_pc   = flush ? ex_pc : '0;
        redirect = active & ~freeze & (pend_valid_q | br_req);
        redir_pc = '0;
        if (redirect) begin
            redir_pc = pend_valid_q ? pend_pc_q : br_pc;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        if (ex_req) begin
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end else if (freeze) begin
            cnt_d = (cnt_q >= TMO) ? TMO : cnt_q + 1'b1;
            // Only the oldest taken branch is kept; later ones are wrong-path.
            if (br_req && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = br_pc;
            end
        end else begin
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end
        if (cnt_d == TMO) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stall_cnt = cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb/tb_pipe_ctrl_gen.sv - self-checking bench for pipe_ctrl_gen
module tb_pipe_ctrl_gen;

    localparam int STAGES = 6;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 8;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stall_req;
    logic              ex_req;
    logic [PC_W-1:0]   ex_pc;
    logic              br_req;
    logic [PC_W-1:0]   br_pc;
    logic [STAGES-1:0] d_stall;
    logic [STAGES-1:0] d_bubble;
    logic              d_flush;
    logic [PC_W-1:0]   d_new_pc;
    logic              d_redirect;
    logic [PC_W-1:0]   d_redir_pc;
    logic [CNT_W-1:0]  d_cnt;
    logic              d_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit              m_pend;
    logic [PC_W-1:0] m_pend_pc;
    int              m_cnt;
    bit              m_tmo;
    logic [STAGES-1:0] e_stall, e_bubble;
    logic              e_flush, e_redirect;
    logic [PC_W-1:0]   e_new_pc, e_redir_pc;

    pipe_ctrl_gen #(.STAGES(STAGES), .BR_STAGE(2), .PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .stall_req(stall_req), .ex_req(ex_req), .ex_pc(ex_pc),
        .br_req(br_req), .br_pc(br_pc), .stall(d_stall), .bubble(d_bubble), .flush(d_flush),
        .new_pc(d_new_pc), .redirect(d_redirect), .redir_pc(d_redir_pc),
        .stall_cnt(d_cnt), .timeout(d_timeout)
    );

    always #5 clk = ~clk;

    function automatic int top_bit(input logic [STAGES-1:0] v);
        int h = -1;
        for (int i = 0; i < STAGES; i++) if (v[i]) h = i;
        return h;
    endfunction

    task automatic model_comb();
        int h;
        e_stall = '0; e_bubble = '0; e_flush = 0; e_new_pc = '0; e_redirect = 0; e_redir_pc = '0;
        if (rst && ex_req) begin
            e_flush  = 1;
            e_new_pc = ex_pc;
        end else if (rst) begin
            h = top_bit(stall_req);
            if (h >= 0) begin
                e_stall  = STAGES'((1 << (h + 1)) - 1);
                e_bubble = (h < STAGES - 1) ? STAGES'(1 << h) : '0;
            end else if (m_pend) begin
                e_redirect = 1; e_redir_pc = m_pend_pc;
            end else if (br_req) begin
                e_redirect = 1; e_redir_pc = br_pc;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_pend = 0; m_pend_pc = '0; m_cnt = 0; m_tmo = 0;
        end else if (ex_req) begin
            m_pend = 0; m_cnt = 0;
        end else if (stall_req != 0) begin
            m_cnt = (m_cnt + 1 > TMO) ? TMO : m_cnt + 1;
            if (m_cnt == TMO) m_tmo = 1;
            if (br_req && !m_pend) begin m_pend = 1; m_pend_pc = br_pc; end
        end else begin
            m_cnt = 0; m_pend = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_req = '0; ex_req = 0; ex_pc = '0; br_req = 0; br_pc = '0;
    endtask

    task automatic test_reset();
        rst = 0; stall_req = 6'b101101; ex_req = 0; br_req = 1; br_pc = 32'h1234; ex_pc = 32'h55;
        #1;
        n_checks++; if (d_stall !== '0 || d_bubble !== '0) begin n_fail++; $display("FAIL reset_stall_bubble got %b/%b want 0/0", d_stall, d_bubble); end
        n_checks++; if (d_redirect !== 0 || d_redir_pc !== '0) begin n_fail++; $display("FAIL reset_redirect got %b/%h want 0/0", d_redirect, d_redir_pc); end
        ex_req = 1; #1;
        n_checks++; if (d_flush !== 0 || d_new_pc !== '0) begin n_fail++; $display("FAIL reset_flush got %b/%h want 0/0", d_flush, d_new_pc); end
        tick();
        n_checks++; if (d_cnt !== '0 || d_timeout !== 0) begin n_fail++; $display("FAIL reset_regs got %0d/%b want 0/0", d_cnt, d_timeout); end
        rst = 1; idle_inputs(); tick();
    endtask

    task automatic test_load_use();
        stall_req = 6'b000100; #1;
        n_checks++; if (d_stall !== 6'b000111) begin n_fail++; $display("FAIL load_use_stall got %b want 000111", d_stall); end
        n_checks++; if (d_bubble !== 6'b000100) begin n_fail++; $display("FAIL load_use_bubble got %b want 000100", d_bubble); end
        tick();
        stall_req = '0; #1;
        n_checks++; if (d_stall !== '0 || d_bubble !== '0) begin n_fail++; $display("FAIL load_use_release got %b/%b want 0/0", d_stall, d_bubble); end
        tick();
    endtask

    task automatic test_nested();
        stall_req = 6'b010010; #1;
        n_checks++; if (d_stall !== 6'b011111 || d_bubble !== 6'b010000) begin n_fail++; $display("FAIL nested_both got %b/%b want 011111/010000", d_stall, d_bubble); end
        tick();
        stall_req = 6'b000010; #1;
        n_checks++; if (d_stall !== 6'b000011 || d_bubble !== 6'b000010) begin n_fail++; $display("FAIL nested_drop got %b/%b want 000011/000010", d_stall, d_bubble); end
        tick();
        stall_req = 6'b100000; #1;
        n_checks++; if (d_stall !== 6'b111111 || d_bubble !== 6'b000000) begin n_fail++; $display("FAIL nested_wb got %b/%b want 111111/000000", d_stall, d_bubble); end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_buffered_branch();
        stall_req = 6'b000010; br_req = 1; br_pc = 32'h0000_1000; #1;
        n_checks++; if (d_redirect !== 0 || d_redir_pc !== '0) begin n_fail++; $display("FAIL bbr_cycle0 got %b/%h want 0/0", d_redirect, d_redir_pc); end
        tick();
        stall_req = '0; br_req = 1; br_pc = 32'h0000_2000; #1;
        n_checks++; if (d_redirect !== 1 || d_redir_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL bbr_cycle1 got %b/%h want 1/00001000", d_redirect, d_redir_pc); end
        tick();
        br_req = 0; #1;
        n_checks++; if (d_redirect !== 0 || d_redir_pc !== '0) begin n_fail++; $display("FAIL bbr_cycle2 got %b/%h want 0/0", d_redirect, d_redir_pc); end
        br_req = 1; br_pc = 32'h0000_3000; #1;
        n_checks++; if (d_redirect !== 1 || d_redir_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL br_direct got %b/%h want 1/00003000", d_redirect, d_redir_pc); end
        tick();
        idle_inputs(); tick();
    endtask

    task automatic test_exception();
        stall_req = 6'b000010; br_req = 1; br_pc = 32'h0000_1000; tick();
        br_req = 0; ex_req = 1; ex_pc = 32'hBFC0_0380; stall_req = 6'b001000; #1;
        n_checks++; if (d_flush !== 1 || d_new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL exc_flush got %b/%h want 1/bfc00380", d_flush, d_new_pc); end
        n_checks++; if (d_stall !== '0 || d_bubble !== '0 || d_redirect !== 0) begin n_fail++; $display("FAIL exc_quiet got %b/%b/%b want 0/0/0", d_stall, d_bubble, d_redirect); end
        tick();
        idle_inputs(); #1;
        n_checks++; if (d_redirect !== 0 || d_flush !== 0 || d_cnt !== '0) begin n_fail++; $display("FAIL exc_after got %b/%b/%0d want 0/0/0", d_redirect, d_flush, d_cnt); end
        tick();
        n_checks++; if (d_redirect !== 0) begin n_fail++; $display("FAIL exc_no_late_redirect got %b want 0", d_redirect); end
    endtask

    task automatic test_watchdog();
        stall_req = 6'b000001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++; if (d_cnt !== CNT_W'((k < TMO) ? k : TMO)) begin n_fail++; $display("FAIL wd_cnt edge %0d got %0d want %0d", k, d_cnt, (k < TMO) ? k : TMO); end
            n_checks++; if (d_timeout !== (k >= TMO)) begin n_fail++; $display("FAIL wd_timeout edge %0d got %b want %b", k, d_timeout, k >= TMO); end
        end
        stall_req = '0; tick();
        n_checks++; if (d_cnt !== '0 || d_timeout !== 1) begin n_fail++; $display("FAIL wd_release got %0d/%b want 0/1", d_cnt, d_timeout); end
    endtask

    task automatic test_reset_mid();
        stall_req = 6'b000001; br_req = 1; br_pc = 32'hCAFE_0000;
        for (int k = 0; k < 3; k++) tick();
        n_checks++; if (d_cnt !== 8'd3 || d_timeout !== 1) begin n_fail++; $display("FAIL rmid_setup got %0d/%b want 3/1", d_cnt, d_timeout); end
        rst = 0; ex_req = 1; ex_pc = 32'h77; stall_req = 6'b011000; #1;
        n_checks++; if (d_flush !== 0 || d_stall !== '0 || d_redirect !== 0) begin n_fail++; $display("FAIL rmid_outputs got %b/%b/%b want 0/0/0", d_flush, d_stall, d_redirect); end
        tick();
        n_checks++; if (d_cnt !== '0 || d_timeout !== 0) begin n_fail++; $display("FAIL rmid_regs got %0d/%b want 0/0", d_cnt, d_timeout); end
        rst = 1; idle_inputs(); #1;
        n_checks++; if (d_redirect !== 0) begin n_fail++; $display("FAIL rmid_no_redirect got %b want 0", d_redirect); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst    = ($urandom_range(0, 49) != 0);
            ex_req = ($urandom_range(0, 15) == 0);
            ex_pc  = $urandom;
            if ($urandom_range(0, 3) == 0) stall_req = ($urandom_range(0, 1) == 0) ? '0 : STAGES'($urandom);
            br_req = ($urandom_range(0, 2) == 0);
            br_pc  = $urandom;
            #1;
            model_comb();
            n_checks++; if (d_stall !== e_stall || d_bubble !== e_bubble) begin n_fail++; $display("FAIL rand_stall c%0d got %b/%b want %b/%b", c, d_stall, d_bubble, e_stall, e_bubble); end
            n_checks++; if (d_flush !== e_flush || d_new_pc !== e_new_pc) begin n_fail++; $display("FAIL rand_flush c%0d got %b/%h want %b/%h", c, d_flush, d_new_pc, e_flush, e_new_pc); end
            n_checks++; if (d_redirect !== e_redirect || d_redir_pc !== e_redir_pc) begin n_fail++; $display("FAIL rand_redirect c%0d got %b/%h want %b/%h", c, d_redirect, d_redir_pc, e_redirect, e_redir_pc); end
            n_checks++; if (d_cnt !== CNT_W'(m_cnt) || d_timeout !== m_tmo) begin n_fail++; $display("FAIL rand_wd c%0d got %0d/%b want %0d/%b", c, d_cnt, d_timeout, m_cnt, m_tmo); end
            tick();
        end
    endtask

    initial begin
        rst = 0; idle_inputs();
        m_pend = 0; m_pend_pc = '0; m_cnt = 0; m_tmo = 0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_nested();
        test_buffered_branch();
        test_exception();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
